// File: rtl/lockpick_session_arbiter.sv
// lockpick_session_arbiter
// Shares one lock-pick engine among four players. A player with an active,
// non-locked request wins the engine through round-robin arbitration, streams
// 64 bytes into it (zero-padded if the player stalls or withdraws), receives
// the engine's 32-byte response, and gets a one-cycle outcome pulse. The
// "retry" status starts another 64-byte attempt within the same session; the
// "locked out" status bars the player for LOCKOUT_CYCLES cycles.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   req[3:0]             per-player session request (level)
//   in_valid[3:0]        per-player byte valid
//   in_data[31:0]        per-player byte, player p on [8p+7:8p]
//   in_ready             granted player's byte accepted this cycle
//   grant[3:0]           one-hot engine owner, zero when idle
//   eng_start            one-cycle engine start pulse
//   eng_input_enable     byte strobe to engine
//   eng_input_data[7:0]  byte to engine (0x00 while padding)
//   eng_output_valid, eng_output_data[7:0], eng_status[1:0]  from engine
//   out_valid, out_data[7:0], out_player[1:0]  forwarded response stream
//   result_valid, result_status[1:0], result_player[1:0]  attempt outcome
//   locked[3:0]          per-player lockout active

module lockpick_session_arbiter #(
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int IDLE_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [3:0]  grant,
  output logic        eng_start,
  output logic        eng_input_enable,
  output logic [7:0]  eng_input_data,
  input  logic        eng_output_valid,
  input  logic [7:0]  eng_output_data,
  input  logic [1:0]  eng_status,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [1:0]  out_player,
  output logic        result_valid,
  output logic [1:0]  result_status,
  output logic [1:0]  result_player,
  output logic [3:0]  locked
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_FEED, S_DRAIN, S_CHECK
  } state_t;

  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES);
  localparam logic [7:0]  IDLE_MAX  = 8'(IDLE_TIMEOUT);

  state_t      r_state;
  logic [3:0]  r_grant;
  logic [1:0]  r_gidx;       // index of current grantee
  logic [1:0]  r_rr;         // first player examined at next arbitration
  logic        r_eng_start;
  logic [5:0]  r_cnt;        // bytes sent this attempt, wraps at 64
  logic [4:0]  r_ocnt;       // response bytes forwarded
  logic [7:0]  r_idle;       // FEED cycles since last accepted byte
  logic        r_pad;        // padding latched for rest of attempt
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic [1:0]  r_out_player;
  logic        r_res_valid;
  logic [1:0]  r_res_status;
  logic [1:0]  r_res_player;

  logic [3:0]  w_locked;
  logic [3:0]  w_lock_load;
  logic [3:0]  w_elig;
  logic        w_pick_valid;
  logic [1:0]  w_pick;
  logic        w_padding;
  logic        w_accept;
  logic        w_feed_en;

  // Per-player lockout counters
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lock
      logic [15:0] r_lock;
      assign w_lock_load[gi] = (r_state == S_CHECK) && (eng_status == 2'b11) &&
                               (r_gidx == 2'(gi));
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_lock <= '0;
        end else if (w_lock_load[gi]) begin
          r_lock <= LOCK_LOAD;
        end else if (r_lock != 16'd0) begin
          r_lock <= r_lock - 16'd1;
        end
      end
      assign w_locked[gi] = (r_lock != 16'd0);
    end
  endgenerate

  assign w_elig = req & ~w_locked;

  // Round-robin pick: scan downward so the lowest offset from r_rr wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = r_rr;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[r_rr + 2'(k)]) begin
        w_pick_valid = 1'b1;
        w_pick       = r_rr + 2'(k);
      end
    end
  end

  // Padding starts on timeout or withdrawal and then sticks for the attempt.
  assign w_padding = (r_state == S_FEED) &&
                     (r_pad || (r_idle == IDLE_MAX) || !req[r_gidx]);
  assign w_accept  = (r_state == S_FEED) && !w_padding && in_valid[r_gidx];
  assign w_feed_en = w_accept || w_padding;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_rr         <= '0;
      r_eng_start  <= 1'b0;
      r_cnt        <= '0;
      r_ocnt       <= '0;
      r_idle       <= '0;
      r_pad        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_player <= '0;
      r_res_valid  <= 1'b0;
      r_res_status <= '0;
      r_res_player <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) r_state <= S_ARB;
        end
        S_ARB: begin
          // Requests may have dropped since IDLE; fall back if nobody is left.
          if (w_pick_valid) begin
            r_grant     <= 4'b0001 << w_pick;
            r_gidx      <= w_pick;
            r_rr        <= w_pick + 2'd1;
            r_eng_start <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_idle  <= '0;
          r_pad   <= 1'b0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          r_pad <= w_padding;
          if (w_accept) begin
            r_idle <= '0;
          end else if (!w_padding) begin
            r_idle <= r_idle + 8'd1;
          end
          if (w_feed_en) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd63) begin
              r_ocnt  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (eng_output_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= eng_output_data;
            r_out_player <= r_gidx;
            r_ocnt       <= r_ocnt + 5'd1;
            if (r_ocnt == 5'd31) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_res_valid  <= 1'b1;
          r_res_status <= eng_status;
          r_res_player <= r_gidx;
          if (eng_status == 2'b01) begin
            // Retry: same grantee, no new engine start.
            r_cnt   <= '0;
            r_idle  <= '0;
            r_pad   <= 1'b0;
            r_state <= S_FEED;
          end else begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready         = w_accept;
  assign eng_input_enable = w_feed_en;
  assign eng_input_data   = w_accept ? in_data[{r_gidx, 3'b000} +: 8] : 8'h00;
  assign grant            = r_grant;
  assign eng_start        = r_eng_start;
  assign out_valid        = r_out_valid;
  assign out_data         = r_out_data;
  assign out_player       = r_out_player;
  assign result_valid     = r_res_valid;
  assign result_status    = r_res_status;
  assign result_player    = r_res_player;
  assign locked           = w_locked;

endmodule

// File: tb/tb_lockpick_session_arbiter.sv
module tb_lockpick_session_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req, in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  grant;
  logic        eng_start, eng_input_enable;
  logic [7:0]  eng_input_data;
  logic        eng_output_valid;
  logic [7:0]  eng_output_data;
  logic [1:0]  eng_status;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_player;
  logic        result_valid;
  logic [1:0]  result_status, result_player;
  logic [3:0]  locked;

  lockpick_session_arbiter #(.LOCKOUT_CYCLES(1024), .IDLE_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .grant(grant), .eng_start(eng_start),
    .eng_input_enable(eng_input_enable), .eng_input_data(eng_input_data),
    .eng_output_valid(eng_output_valid), .eng_output_data(eng_output_data),
    .eng_status(eng_status), .out_valid(out_valid), .out_data(out_data),
    .out_player(out_player), .result_valid(result_valid),
    .result_status(result_status), .result_player(result_player), .locked(locked)
  );

  typedef struct packed { logic [7:0] d; logic [1:0] p; } out_t;
  typedef struct packed { logic [1:0] s; logic [1:0] p; } res_t;
  typedef struct {
    logic [3:0] mask; int stop; int p; logic [1:0] st;
    bit spur; bit extra; int pad;
  } vec_t;

  out_t out_q[$];
  res_t res_q[$];
  int tests = 0, failed = 0;

  // Player / engine model state
  logic [3:0] req_mask;
  int stop_lim, cur_p;
  int sent[4];
  logic [1:0] st0, st1, st2;
  bit spur_en, spur_done, extra_en, cur_real;
  int e_cnt, e_drain, e_idx, extra_left;
  // Per-session observation counters
  int cyc, n_start, n_en, n_pad, n_out, n_res, n_bad, n_lock2, n_grant_cyc;
  int last_acc, first_pad;
  logic [3:0] sess_grant;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int p, input int n);
    return 8'((p * 71 + n * 13) & 255) ^ 8'h5A;
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {grant, in_ready, eng_start, eng_input_enable, eng_input_data,
                 out_valid, out_data, out_player, result_valid, result_status,
                 result_player, locked}, 64'd0);
  endtask

  task automatic drive();
    req = req_mask;
    for (int p = 0; p < 4; p++) begin
      in_valid[p]       = req_mask[p] && (sent[p] < stop_lim);
      in_data[p*8 +: 8] = byte_of(p, sent[p]);
    end
    cur_real         = 1'b0;
    eng_output_valid = 1'b0;
    eng_output_data  = 8'h00;
    if (e_drain > 0) begin
      cur_real         = 1'b1;
      eng_output_valid = 1'b1;
      eng_output_data  = 8'hCE ^ 8'((e_idx * cur_p) & 255);
    end else if (extra_left > 0) begin
      eng_output_valid = 1'b1;
      eng_output_data  = 8'hEE;
      extra_left--;
    end else if (spur_en && !spur_done && e_cnt == 20) begin
      eng_output_valid = 1'b1;
      eng_output_data  = 8'hBB;
      spur_done        = 1'b1;
    end
    eng_status = (n_res == 0) ? st0 : (n_res == 1) ? st1 : st2;
  endtask

  task automatic observe();
    out_t o;
    res_t r;
    cyc++;
    if (eng_start) n_start++;
    if (in_ready && !eng_input_enable) n_bad++;
    if (eng_input_enable) begin
      n_en++;
      e_cnt++;
      if (in_ready) begin
        check("feed_byte", eng_input_data, byte_of(cur_p, sent[cur_p]));
        sent[cur_p]++;
        last_acc = cyc;
      end else begin
        n_pad++;
        if (eng_input_data != 8'h00) n_bad++;
        if (first_pad < 0) first_pad = cyc;
      end
      if (e_cnt == 64) begin
        e_cnt = 0; e_drain = 32; e_idx = 0;
      end
    end
    if (cur_real) begin
      out_q.push_back('{d: eng_output_data, p: 2'(cur_p)});
      e_drain--;
      e_idx++;
      if (e_drain == 0) extra_left = extra_en ? 3 : 0;
    end
    if (out_valid) begin
      n_out++;
      check("out_expected", out_q.size() != 0, 1);
      if (out_q.size() != 0) begin
        o = out_q.pop_front();
        check("out_data", out_data, o.d);
        check("out_player", out_player, o.p);
      end
    end
    if (result_valid) begin
      n_res++;
      check("result_expected", res_q.size() != 0, 1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        check("result_status", result_status, r.s);
        check("result_player", result_player, r.p);
      end
    end
    if (locked[2]) n_lock2++;
    if (grant != 4'b0) begin
      n_grant_cyc++;
      if (sess_grant == 4'b0) sess_grant = grant;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic clear_counts();
    n_start = 0; n_en = 0; n_pad = 0; n_out = 0; n_res = 0; n_bad = 0;
    n_lock2 = 0; n_grant_cyc = 0; last_acc = -1; first_pad = -1;
    sess_grant = 4'b0;
    for (int p = 0; p < 4; p++) sent[p] = 0;
  endtask

  task automatic run_session(input logic [3:0] mask, input int stop, input int p,
                             input int natt, input logic [1:0] s0, input logic [1:0] s1,
                             input logic [1:0] s2, input bit spur, input bit extra);
    bit done;
    req_mask = mask; stop_lim = stop; cur_p = p;
    st0 = s0; st1 = s1; st2 = s2;
    spur_en = spur; spur_done = 1'b0; extra_en = extra;
    clear_counts();
    for (int a = 0; a < natt; a++)
      res_q.push_back('{s: (a == 0) ? s0 : (a == 1) ? s1 : s2, p: 2'(p)});
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      cycle();
      if (n_res == natt && grant == 4'b0) done = 1'b1;
    end
    check("session_done", done, 1);
  endtask

  vec_t vecs[8];

  initial begin
    // Single-attempt sessions: {mask, bytes player offers, expected grantee,
    // engine status, spurious FEED valid, extra DRAIN valids, expected pad bytes}
    vecs[0] = '{4'b0001, 64, 0, 2'b10, 1'b0, 1'b0, 0};
    vecs[1] = '{4'b1111, 64, 1, 2'b10, 1'b0, 1'b0, 0};
    vecs[2] = '{4'b1111, 64, 2, 2'b10, 1'b0, 1'b0, 0};
    vecs[3] = '{4'b1111, 64, 3, 2'b10, 1'b0, 1'b0, 0};
    vecs[4] = '{4'b1111, 64, 0, 2'b10, 1'b0, 1'b0, 0};
    vecs[5] = '{4'b0010, 10, 1, 2'b10, 1'b0, 1'b0, 54};
    vecs[6] = '{4'b1000, 64, 3, 2'b00, 1'b0, 1'b0, 0};
    vecs[7] = '{4'b0100, 64, 2, 2'b10, 1'b1, 1'b1, 0};

    rst = 1'b0; req = 4'b0; in_valid = 4'b0; in_data = 32'b0;
    eng_output_valid = 1'b0; eng_output_data = 8'h00; eng_status = 2'b00;
    req_mask = 4'b0; stop_lim = 0; cur_p = 0; st0 = 0; st1 = 0; st2 = 0;
    spur_en = 0; spur_done = 0; extra_en = 0; cur_real = 0;
    e_cnt = 0; e_drain = 0; e_idx = 0; extra_left = 0; cyc = 0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_session(vecs[i].mask, vecs[i].stop, vecs[i].p, 1, vecs[i].st, 2'b00, 2'b00,
                  vecs[i].spur, vecs[i].extra);
      $display("[TB] vec %0d: grant=%b starts=%0d enables=%0d pads=%0d outs=%0d",
               i, sess_grant, n_start, n_en, n_pad, n_out);
      check($sformatf("v%0d_grant", i), sess_grant, 4'b0001 << vecs[i].p);
      check($sformatf("v%0d_starts", i), n_start, 1);
      check($sformatf("v%0d_enables", i), n_en, 64);
      check($sformatf("v%0d_pads", i), n_pad, vecs[i].pad);
      check($sformatf("v%0d_outs", i), n_out, 32);
      check($sformatf("v%0d_results", i), n_res, 1);
      check($sformatf("v%0d_protocol", i), n_bad, 0);
      check($sformatf("v%0d_outq_empty", i), out_q.size(), 0);
      check($sformatf("v%0d_locked", i), locked, 4'b0);
      if (vecs[i].stop < 64)
        check($sformatf("v%0d_idle_gap", i), first_pad - last_acc, 256);
    end

    // Retry, retry, lockout for player 2 within one session.
    run_session(4'b0100, 192, 2, 3, 2'b01, 2'b01, 2'b11, 1'b0, 1'b0);
    $display("[TB] lockout session: grant=%b starts=%0d enables=%0d outs=%0d results=%0d",
             sess_grant, n_start, n_en, n_out, n_res);
    check("lk_grant", sess_grant, 4'b0100);
    check("lk_starts", n_start, 1);
    check("lk_enables", n_en, 192);
    check("lk_outs", n_out, 96);
    check("lk_results", n_res, 3);
    check("lk_pads", n_pad, 0);
    check("lk_locked_now", locked, 4'b0100);
    n_grant_cyc = 0;
    repeat (1000) cycle();
    req_mask = 4'b0;
    repeat (100) cycle();
    $display("[TB] lockout window: locked cycles=%0d grant cycles=%0d", n_lock2, n_grant_cyc);
    check("lk_locked_cycles", n_lock2, 1024);
    check("lk_req_ignored", n_grant_cyc, 0);
    check("lk_locked_clear", locked, 4'b0);

    // Asynchronous reset in the middle of FEED, then a fresh session.
    req_mask = 4'b0010; stop_lim = 64; cur_p = 1;
    st0 = 2'b10; spur_en = 0; extra_en = 0;
    clear_counts();
    for (int c = 0; c < 300 && n_en < 30; c++) cycle();
    check("rs_reached_byte30", n_en, 30);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    $display("[TB] async reset at byte %0d: grant=%b enable=%b", n_en, grant, eng_input_enable);
    e_cnt = 0; e_drain = 0; extra_left = 0;
    out_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_session(4'b0010, 64, 1, 1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    $display("[TB] post-reset session: grant=%b starts=%0d enables=%0d outs=%0d",
             sess_grant, n_start, n_en, n_out);
    check("rs_grant", sess_grant, 4'b0010);
    check("rs_starts", n_start, 1);
    check("rs_enables", n_en, 64);
    check("rs_outs", n_out, 32);
    check("rs_pads", n_pad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lockpick_session_arbiter.md
LOCKPICK_SESSION_ARBITER -- requirements
Module: lockpick_session_arbiter

Parameters
REQ-001 SHALL provide: LOCKOUT_CYCLES, default 1024, cycles a player is barred after a locked-out session (1..65535).
REQ-002 SHALL provide: IDLE_TIMEOUT, default 255, max cycles without a granted byte in FEED before zero-padding starts (1..255).

Interface
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-player session request, level.
REQ-006 in_valid  input  4  per-player byte valid.
REQ-007 in_data  input  32  per-player byte; player p on bits [8p+7:8p].
REQ-008 in_ready  output  1  granted player's byte accepted this cycle.
REQ-009 grant  output  4  one-hot owner of the engine; zero when idle.
REQ-010 eng_start, eng_input_enable  output  1 each  engine start pulse and byte strobe.
REQ-011 eng_input_data  output  8  byte to engine.
REQ-012 eng_output_valid  input  1; eng_output_data  input  8; eng_status  input  2  from engine.
REQ-013 out_valid  output  1; out_data  output  8; out_player  output  2  forwarded response stream.
REQ-014 result_valid  output  1; result_status  output  2; result_player  output  2  one-cycle session/attempt outcome.
REQ-015 locked  output  4  per-player lockout active.

Function
REQ-016 FSM states: IDLE, ARB, START, FEED, DRAIN, CHECK.
REQ-017 IDLE->ARB when any req bit is set with the matching locked bit clear.
REQ-018 ARB: round-robin from the player after the last grantee, skipping locked players; grant is set at ARB exit and held until the session ends.
REQ-019 START: eng_start=1 for exactly one cycle, then FEED with byte count 0.
REQ-020 FEED: in_ready = in_valid[grantee]; on in_ready, eng_input_enable=1 and eng_input_data = grantee byte in the same cycle (combinational pass-through); count increments.
REQ-021 FEED: if the idle counter reaches IDLE_TIMEOUT, or req[grantee] drops, the arbiter drives 0x00 bytes with eng_input_enable=1 every cycle until 64 bytes are sent; in_ready=0 while padding.
REQ-022 The idle counter resets on every accepted byte.
REQ-023 At count 64 (6-bit counter wraps to 0), FEED->DRAIN.
REQ-024 DRAIN: each eng_output_valid cycle drives out_valid=1, out_data=eng_output_data, out_player=grantee index, all registered with 1-cycle latency; after 32 bytes -> CHECK.
REQ-025 CHECK samples eng_status and pulses result_valid with result_status=eng_status and result_player=grantee.
REQ-026 CHECK, status 01 -> FEED (new attempt, no eng_start, count 0).
REQ-027 CHECK, status 10 -> IDLE, grant=0.
REQ-028 CHECK, status 11 -> IDLE, grant=0, and the grantee's lockout counter loads LOCKOUT_CYCLES.
REQ-029 CHECK, status 00 -> IDLE, grant=0, result_status=00 (protocol error).
REQ-030 Lockout counters decrement each cycle while nonzero; locked[p] = (counter != 0).
REQ-031 A request from a locked player is ignored, not queued.
REQ-032 In DRAIN, eng_output_valid beyond 32 bytes is ignored.
REQ-033 eng_output_valid seen in FEED is dropped.
REQ-034 A session is never preempted by other requests.

Reset
REQ-035 During rst=0: state=IDLE, grant=0, all strobes and valids 0, data outputs 0x00, counters 0, locked=0, RR pointer=player 0.
REQ-036 A mid-session reset clears everything immediately; the engine is reset on the same rst net.

Verification
REQ-037 Single player 0 sends 64 bytes, engine returns 32x 0xCE with status 10 -> grant=0001, one eng_start, 64 enables, 32 out_valid with out_player=0, result_status=10, then IDLE.
REQ-038 All four players request continuously -> grants in order 1,2,3,0 after a session by 0; no player granted twice before the others.
REQ-039 Player 2 gets status 01, 01, 11 -> three FEED/DRAIN rounds, a single eng_start, locked[2]=1 for exactly 1024 cycles, req[2] ignored meanwhile.
REQ-040 Player 1 stops after 10 bytes -> padding starts after 255 idle cycles, 54 zero bytes sent, session completes normally.
REQ-041 rst asserted at FEED byte 30 -> all outputs 0 asynchronously; after release a fresh session starts at count 0.
REQ-042 eng_status=00 at CHECK -> result_status=00, session aborts to IDLE, no lockout.
